// File: rtl/pixel_write_queue_if.sv
// Pixel-side and framebuffer-side signals of the pixel write queue.
// The slave modport is the queue; the master modport is its environment.
interface pixel_write_queue_if;
  logic [7:0]  iX;
  logic [6:0]  iY;
  logic [2:0]  iColour;
  logic        iPlot;
  logic        iClear;
  logic        oReady;
  logic [14:0] oAddr;
  logic [2:0]  oColour;
  logic        oWrEn;
  logic        iMemReady;
  logic [7:0]  oDropCount;
  logic        oBusy;

  modport slave (
    input  iX, iY, iColour, iPlot, iClear, iMemReady,
    output oReady, oAddr, oColour, oWrEn, oDropCount, oBusy
  );

  modport master (
    output iX, iY, iColour, iPlot, iClear, iMemReady,
    input  oReady, oAddr, oColour, oWrEn, oDropCount, oBusy
  );
endinterface

// File: rtl/pixel_write_queue.sv
// Buffers pixel writes from a drawing engine into a FIFO and replays them
// to a framebuffer through one output register, dropping off-screen pixels.
module pixel_write_queue #(
  parameter int DEPTH           = 8,
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120
) (
  input  logic                 iClock,
  input  logic                 iResetn,
  pixel_write_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [14:0]   addr_q, addr_d;
  logic [2:0]    colour_q, colour_d;
  logic [7:0]    drop_q, drop_d;

  logic [14:0]   mem_addr_q [DEPTH];
  logic [2:0]    mem_col_q  [DEPTH];

  logic full, empty, in_range, accept;
  logic push, drop, complete, load;
  logic [14:0] pix_addr;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign in_range = (32'(bus.iX) < 32'(X_SCREEN_PIXELS))
                 && (32'(bus.iY) < 32'(Y_SCREEN_PIXELS));
  assign pix_addr = 15'(bus.iY) * 15'(X_SCREEN_PIXELS)
                  + 15'(bus.iX);

  assign accept   = bus.iPlot && !full && !bus.iClear;
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;
  assign complete = wr_en_q && bus.iMemReady;
  // Refill the output register whenever it is free or being freed.
  assign load     = !empty && (!wr_en_q || complete);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    colour_d = colour_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (load) begin
      wr_en_d  = 1'b1;
      addr_d   = mem_addr_q[rd_ptr_q];
      colour_d = mem_col_q[rd_ptr_q];
    end else if (complete) begin
      wr_en_d = 1'b0;
    end
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    if (bus.iClear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wr_en_d  = 1'b0;
    end
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      colour_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      colour_q <= colour_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge iClock) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= pix_addr;
      mem_col_q[wr_ptr_q]  <= bus.iColour;
    end
  end

  assign bus.oReady     = !full;
  assign bus.oBusy      = !empty || wr_en_q;
  assign bus.oWrEn      = wr_en_q;
  assign bus.oAddr      = addr_q;
  assign bus.oColour    = colour_q;
  assign bus.oDropCount = drop_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: vector table, corner
// sequences and a write scoreboard fed at drive time.
module tb_pixel_write_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pixel_write_queue_if bus();

  pixel_write_queue #(
    .DEPTH(8),
    .X_SCREEN_PIXELS(160),
    .Y_SCREEN_PIXELS(120)
  ) dut (
    .iClock (clk),
    .iResetn(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [14:0] a;
    logic [2:0]  c;
  } wr_t;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    bit          ok;
    logic [14:0] exp_a;
  } vec_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  wr_cnt   = 0;
  int  exp_drop = 0;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(logic [7:0] x, logic [6:0] y,
                         logic [2:0] c, bit exp_acc);
    wr_t w;
    bus.iX = x;
    bus.iY = y;
    bus.iColour = c;
    bus.iPlot = 1'b1;
    if (exp_acc) begin
      w.a = 15'(y) * 15'd160 + 15'(x);
      w.c = c;
      exp_q.push_back(w);
    end
    step();
    bus.iPlot = 1'b0;
  endtask

  // Inputs only change just after a rising edge, so at the falling
  // edge the handshake seen here is the one the next edge will take.
  always @(negedge clk) begin
    if (rst_n && bus.oWrEn && bus.iMemReady) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", int'(bus.oAddr), int'(w.a));
        chk("wr_colour", int'(bus.oColour), int'(w.c));
      end
    end
  end

  vec_t vt[8];
  int   wr0;
  logic [14:0] hold_a;

  initial begin
    vt[0] = '{8'd5,   7'd3,   3'b101, 1'b1, 15'd485};
    vt[1] = '{8'd159, 7'd119, 3'b011, 1'b1, 15'd19199};
    vt[2] = '{8'd160, 7'd0,   3'b111, 1'b0, 15'd0};
    vt[3] = '{8'd0,   7'd120, 3'b001, 1'b0, 15'd0};
    vt[4] = '{8'd0,   7'd0,   3'b010, 1'b1, 15'd0};
    vt[5] = '{8'd255, 7'd127, 3'b110, 1'b0, 15'd0};
    vt[6] = '{8'd159, 7'd0,   3'b100, 1'b1, 15'd159};
    vt[7] = '{8'd0,   7'd119, 3'b111, 1'b1, 15'd19040};

    rst_n = 1'b0;
    bus.iX = '0;
    bus.iY = '0;
    bus.iColour = '0;
    bus.iPlot = 1'b0;
    bus.iClear = 1'b0;
    bus.iMemReady = 1'b1;
    #12;
    chk("rst_ready", int'(bus.oReady), 1);
    chk("rst_busy", int'(bus.oBusy), 0);
    chk("rst_wren", int'(bus.oWrEn), 0);
    chk("rst_drop", int'(bus.oDropCount), 0);
    rst_n = 1'b1;

    // Single pushes into an idle queue with the framebuffer ready.
    foreach (vt[i]) begin
      push_px(vt[i].x, vt[i].y, vt[i].c, vt[i].ok);
      if (!vt[i].ok) exp_drop++;
      chk("vec_busy", int'(bus.oBusy), int'(vt[i].ok));
      step();
      chk("vec_wren", int'(bus.oWrEn), int'(vt[i].ok));
      if (vt[i].ok) begin
        chk("vec_addr", int'(bus.oAddr), int'(vt[i].exp_a));
        chk("vec_col", int'(bus.oColour), int'(vt[i].c));
      end
      step();
      chk("vec_wren_off", int'(bus.oWrEn), 0);
      chk("vec_drop", int'(bus.oDropCount), exp_drop);
    end

    // Fill with the framebuffer stalled, then drain.
    bus.iMemReady = 1'b0;
    wr0 = wr_cnt;
    for (int i = 0; i < 9; i++)
      push_px(8'(i * 10), 7'(i), 3'(i), 1'b1);
    chk("full_ready", int'(bus.oReady), 0);
    chk("full_wren", int'(bus.oWrEn), 1);
    chk("full_addr", int'(bus.oAddr), 0);
    hold_a = bus.oAddr;
    push_px(8'd77, 7'd7, 3'd7, 1'b0);
    chk("stall_addr", int'(bus.oAddr), int'(hold_a));
    chk("stall_col", int'(bus.oColour), 0);
    chk("stall_ready", int'(bus.oReady), 0);
    bus.iMemReady = 1'b1;
    step();
    chk("drain_ready", int'(bus.oReady), 1);
    for (int i = 0; i < 8; i++) step();
    chk("drain_cnt", wr_cnt - wr0, 9);
    chk("drain_busy", int'(bus.oBusy), 0);

    // Flush while stalled; a same-cycle push must be refused.
    bus.iMemReady = 1'b0;
    for (int i = 0; i < 4; i++)
      push_px(8'(i + 1), 7'd50, 3'd2, 1'b1);
    bus.iClear = 1'b1;
    bus.iX = 8'd9;
    bus.iY = 7'd9;
    bus.iPlot = 1'b1;
    step();
    bus.iClear = 1'b0;
    bus.iPlot = 1'b0;
    exp_q.delete();
    chk("clr_wren", int'(bus.oWrEn), 0);
    chk("clr_busy", int'(bus.oBusy), 0);
    chk("clr_ready", int'(bus.oReady), 1);
    chk("clr_drop", int'(bus.oDropCount), exp_drop);
    wr0 = wr_cnt;
    bus.iMemReady = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("clr_nowr", wr_cnt - wr0, 0);

    // Asynchronous reset with work pending.
    bus.iMemReady = 1'b0;
    for (int i = 0; i < 3; i++)
      push_px(8'd20, 7'(i), 3'd6, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_wren", int'(bus.oWrEn), 0);
    chk("arst_addr", int'(bus.oAddr), 0);
    chk("arst_col", int'(bus.oColour), 0);
    chk("arst_drop", int'(bus.oDropCount), 0);
    chk("arst_busy", int'(bus.oBusy), 0);
    chk("arst_ready", int'(bus.oReady), 1);
    exp_q.delete();
    exp_drop = 0;
    step();
    rst_n = 1'b1;
    bus.iMemReady = 1'b1;
    wr0 = wr_cnt;
    push_px(8'd1, 7'd1, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_wr", wr_cnt - wr0, 1);
    chk("post_rst_drop", int'(bus.oDropCount), 0);

    // Drop counter saturation.
    wr0 = wr_cnt;
    bus.iX = 8'd200;
    bus.iY = 7'd0;
    bus.iPlot = 1'b1;
    for (int i = 0; i < 300; i++) step();
    bus.iPlot = 1'b0;
    chk("sat_drop", int'(bus.oDropCount), 255);
    step();
    chk("sat_hold", int'(bus.oDropCount), 255);
    chk("sat_nowr", wr_cnt - wr0, 0);
    chk("sat_wren", int'(bus.oWrEn), 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_write_queue.md
PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

Interface
REQ-001 Parameter DEPTH, 8, FIFO entry count (power of two, >=2).
REQ-002 Parameter X_SCREEN_PIXELS, 160, screen width in pixels.
REQ-003 Parameter Y_SCREEN_PIXELS, 120, screen height in pixels.
REQ-004 iClock  in  1  the single clock; all state changes on rising edge.
REQ-005 iResetn  in  1  reset, asynchronous, active-low.
REQ-006 iX  in  8  pixel column from the drawing engine.
REQ-007 iY  in  7  pixel row from the drawing engine.
REQ-008 iColour  in  3  pixel colour {R,G,B}.
REQ-009 iPlot  in  1  write request, qualified by oReady.
REQ-010 iClear  in  1  synchronous flush of all queued and pending writes.
REQ-011 oReady  out  1  high when the FIFO holds fewer than DEPTH entries.
REQ-012 oAddr  out  15  framebuffer word address of the pending write.
REQ-013 oColour  out  3  colour of the pending write.
REQ-014 oWrEn  out  1  pending-write valid toward framebuffer.
REQ-015 iMemReady  in  1  framebuffer accepts the write this cycle.
REQ-016 oDropCount  out  8  saturating count of rejected out-of-range pixels.
REQ-017 oBusy  out  1  high when FIFO non-empty or oWrEn high.

Function
REQ-018 The block SHALL accept a pixel on the rising edge where iPlot=1, oReady=1 and iClear=0.
REQ-019 An accepted pixel with iX>=X_SCREEN_PIXELS or iY>=Y_SCREEN_PIXELS SHALL be discarded, not enqueued, and SHALL increment oDropCount, saturating at 255.
REQ-020 iPlot while oReady=0 SHALL be ignored entirely: no enqueue, no drop count change.
REQ-021 Enqueued entries SHALL store address = iY*X_SCREEN_PIXELS + iX (15-bit, computed at enqueue) and iColour.
REQ-022 A write completes on the edge where oWrEn=1 and iMemReady=1.
REQ-023 The output register SHALL load the FIFO head on any edge where FIFO non-empty and (oWrEn=0 or a write completes); otherwise oWrEn SHALL clear on completion.
REQ-024 While oWrEn=1 and iMemReady=0, oAddr, oColour and oWrEn SHALL hold stable.
REQ-025 Latency: pixel accepted at edge k into empty, idle queue SHALL present oWrEn=1 from edge k+1; sustained throughput one write per cycle.
REQ-026 Writes SHALL reach the framebuffer in acceptance order; none duplicated or lost except by REQ-019/REQ-027.
REQ-027 iClear=1 SHALL, on the next edge, empty the FIFO, clear oWrEn, block acceptance that cycle, and leave oDropCount unchanged.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged; full FIFO (DEPTH entries) SHALL drive oReady=0 regardless of a same-cycle pop.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL span 0..DEPTH.
REQ-030 oReady and oBusy SHALL be combinational from registered state only (no path from iPlot or iMemReady).

Reset
REQ-031 iResetn=0 SHALL immediately, without a clock, clear FIFO pointers and occupancy, oWrEn, oAddr, oColour and oDropCount to 0.
REQ-032 During and after reset oReady SHALL be 1 and oBusy 0; a write pending when reset asserts SHALL be abandoned.
REQ-033 First acceptance SHALL be possible on the first rising edge after iResetn deasserts.

Verification
REQ-034 Reset, iMemReady=1, push x=5,y=3,colour=3'b101 -> next cycle oWrEn=1 for one cycle, oAddr=485, oColour=3'b101.
REQ-035 Push x=159,y=119 then x=160,y=0 then x=0,y=120 -> one write oAddr=19199; oDropCount=2; no further oWrEn.
REQ-036 iMemReady=0, push one pixel per cycle -> nine accepted (one pending, eight queued), oReady=0 from then; oAddr/oColour stable; raise iMemReady -> nine writes on consecutive cycles in order, oReady returns high after first completion.
REQ-037 Four pixels queued with iMemReady=0, pulse iClear -> next cycle oWrEn=0, oBusy=0, oReady=1, oDropCount unchanged, no writes after iMemReady=1.
REQ-038 Three pixels queued, drive iResetn low between edges -> outputs 0 before next edge; after release no writes emitted, oDropCount=0.
REQ-039 300 consecutive accepted out-of-range pushes -> oDropCount=255, holds 255, no oWrEn.
